// File: rtl/ni_response_outstanding_table.sv
// ni_response_outstanding_table: age-ordered table of outstanding NI requests retired by response source
module ni_response_outstanding_table #(
  parameter int SRC_WD = 8,
  parameter int DEPTH = 4,
  parameter int STRICT_ORDER = 1,
  localparam int CNT_WD = $clog2(DEPTH + 1),
  localparam int IDX_WD = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              response_awaited,
  input  logic              wait_read_response,
  input  logic              processing_response,
  input  logic [SRC_WD-1:0] transaction_target,
  input  logic              transaction_complete,
  input  logic [SRC_WD-1:0] message_source,
  output logic              full_response,
  output logic              table_full,
  output logic [CNT_WD-1:0] outstanding_count,
  output logic              packet_type_is_read,
  output logic [SRC_WD-1:0] head_target,
  output logic              resp_mismatch
);
  logic [SRC_WD-1:0] tgt_q [DEPTH];
  logic [SRC_WD-1:0] tgt_n [DEPTH];
  logic [DEPTH-1:0]  rd_q, rd_n;
  logic [CNT_WD-1:0] cnt, cnt_n, wr_idx;
  logic [DEPTH-1:0]  match;
  logic [IDX_WD-1:0] sel;
  logic              hit, alloc, retire;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) match[i] = (i < int'(cnt)) && (tgt_q[i] == message_source);
    hit = 1'b0;
    sel = '0;
    if (STRICT_ORDER != 0) hit = match[0];
    else
      for (int i = DEPTH - 1; i >= 0; i--)
        if (match[i]) begin
          hit = 1'b1;
          sel = IDX_WD'(i);
        end
  end
  assign full_response       = cnt != '0;
  assign table_full          = cnt == CNT_WD'(DEPTH);
  assign outstanding_count   = cnt;
  assign packet_type_is_read = hit & rd_q[sel];
  assign head_target         = full_response ? tgt_q[0] : '0;
  assign alloc               = response_awaited & ~processing_response & ~table_full;
  assign retire              = transaction_complete & hit;
  assign wr_idx              = cnt - CNT_WD'(retire);
  assign cnt_n               = cnt + CNT_WD'(alloc) - CNT_WD'(retire);
  // Retire shifts everything above sel down one; the new entry then lands at the compacted tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tgt_n[i] = (retire && i >= int'(sel) && i < DEPTH - 1) ? tgt_q[(i + 1) % DEPTH] : tgt_q[i];
      rd_n[i]  = (retire && i >= int'(sel) && i < DEPTH - 1) ? rd_q[(i + 1) % DEPTH] : rd_q[i];
      tgt_n[i] = (alloc && i == int'(wr_idx)) ? transaction_target : tgt_n[i];
      rd_n[i]  = (alloc && i == int'(wr_idx)) ? wait_read_response : rd_n[i];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) tgt_q[i] <= '0;
      rd_q          <= '0;
      cnt           <= '0;
      resp_mismatch <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) tgt_q[i] <= tgt_n[i];
      rd_q          <= rd_n;
      cnt           <= cnt_n;
      resp_mismatch <= transaction_complete & ~hit;
    end
  end
endmodule

// File: tb/tb_ni_response_outstanding_table.sv
// tb_ni_response_outstanding_table: directed checks of strict and relaxed outstanding tables driven in lockstep
module tb_ni_response_outstanding_table;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic response_awaited = 1'b0, wait_read_response = 1'b0, processing_response = 1'b0;
  logic transaction_complete = 1'b0;
  logic [7:0] transaction_target = '0, message_source = '0;
  logic s_full, s_tf, s_rd, s_mis, r_full, r_tf, r_rd, r_mis;
  logic [2:0] s_cnt, r_cnt;
  logic [7:0] s_head, r_head;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ni_response_outstanding_table #(.SRC_WD(8), .DEPTH(4), .STRICT_ORDER(1)) u_s (
    .clk(clk), .rst(rst), .response_awaited(response_awaited), .wait_read_response(wait_read_response),
    .processing_response(processing_response), .transaction_target(transaction_target),
    .transaction_complete(transaction_complete), .message_source(message_source),
    .full_response(s_full), .table_full(s_tf), .outstanding_count(s_cnt),
    .packet_type_is_read(s_rd), .head_target(s_head), .resp_mismatch(s_mis));
  ni_response_outstanding_table #(.SRC_WD(8), .DEPTH(4), .STRICT_ORDER(0)) u_r (
    .clk(clk), .rst(rst), .response_awaited(response_awaited), .wait_read_response(wait_read_response),
    .processing_response(processing_response), .transaction_target(transaction_target),
    .transaction_complete(transaction_complete), .message_source(message_source),
    .full_response(r_full), .table_full(r_tf), .outstanding_count(r_cnt),
    .packet_type_is_read(r_rd), .head_target(r_head), .resp_mismatch(r_mis));
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic alloc(input int t, input bit rd);
    response_awaited = 1'b1;
    transaction_target = 8'(t);
    wait_read_response = rd;
    tick();
    response_awaited = 1'b0;
  endtask
  task automatic complete(input int src);
    transaction_complete = 1'b1;
    message_source = 8'(src);
    tick();
    transaction_complete = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask
  initial begin
    do_reset();
    chk("rst_cnt", int'(s_cnt), 0);
    chk("rst_full", int'(s_full), 0);
    chk("rst_tf", int'(s_tf), 0);
    chk("rst_head", int'(s_head), 0);
    chk("rst_mis", int'(s_mis), 0);
    // T2 fill past capacity
    for (int t = 1; t <= 5; t++) alloc(t, 1'b0);
    chk("fill_cnt", int'(s_cnt), 4);
    chk("fill_tf", int'(s_tf), 1);
    chk("fill_full", int'(s_full), 1);
    chk("fill_head", int'(s_head), 1);
    chk("fill_cnt_r", int'(r_cnt), 4);
    for (int t = 1; t <= 4; t++) begin
      complete(t);
      chk("drain_cnt", int'(s_cnt), 4 - t);
      chk("drain_head", int'(s_head), t == 4 ? 0 : t + 1);
    end
    chk("drain_tf", int'(s_tf), 0);
    chk("drain_full", int'(s_full), 0);
    complete(5);
    chk("dropped_mis", int'(s_mis), 1);
    chk("dropped_cnt", int'(s_cnt), 0);
    tick();
    chk("mis_pulse_end", int'(s_mis), 0);
    // T3 strict ordering
    alloc(1, 1'b0);
    alloc(2, 1'b0);
    complete(2);
    chk("strict_mis", int'(s_mis), 1);
    chk("strict_cnt", int'(s_cnt), 2);
    chk("relax_nonhead_mis", int'(r_mis), 0);
    chk("relax_nonhead_cnt", int'(r_cnt), 1);
    complete(1);
    chk("strict_mis_clr", int'(s_mis), 0);
    chk("strict_cnt2", int'(s_cnt), 1);
    chk("strict_head2", int'(s_head), 2);
    // T1 asynchronous reset mid-run
    do_reset();
    alloc(7, 1'b0);
    alloc(8, 1'b0);
    alloc(9, 1'b0);
    chk("pre_rst_cnt", int'(s_cnt), 3);
    #2 rst = 1'b0;
    #1;
    chk("async_cnt", int'(s_cnt), 0);
    chk("async_full", int'(s_full), 0);
    chk("async_head", int'(s_head), 0);
    chk("async_cnt_r", int'(r_cnt), 0);
    #2 rst = 1'b1;
    tick();
    chk("post_rst_cnt", int'(s_cnt), 0);
    // T4 relaxed ordering with duplicate targets
    alloc(1, 1'b1);
    alloc(2, 1'b0);
    alloc(1, 1'b0);
    message_source = 8'd1;
    #1;
    chk("relax_rd_first", int'(r_rd), 1);
    chk("strict_rd_first", int'(s_rd), 1);
    complete(1);
    chk("relax_cnt_a", int'(r_cnt), 2);
    chk("relax_head_a", int'(r_head), 2);
    message_source = 8'd1;
    #1;
    chk("relax_rd_second", int'(r_rd), 0);
    message_source = 8'd2;
    #1;
    chk("relax_rd_tgt2", int'(r_rd), 0);
    message_source = 8'd9;
    #1;
    chk("relax_rd_none", int'(r_rd), 0);
    complete(1);
    chk("relax_cnt_b", int'(r_cnt), 1);
    chk("relax_head_b", int'(r_head), 2);
    chk("relax_mis_b", int'(r_mis), 0);
    chk("strict_mis_b", int'(s_mis), 1);
    chk("strict_cnt_b", int'(s_cnt), 2);
    // T5 simultaneous alloc and retire
    do_reset();
    alloc(3, 1'b0);
    alloc(4, 1'b0);
    response_awaited = 1'b1;
    transaction_target = 8'd7;
    wait_read_response = 1'b1;
    complete(3);
    response_awaited = 1'b0;
    chk("simul_cnt", int'(s_cnt), 2);
    chk("simul_head", int'(s_head), 4);
    chk("simul_mis", int'(s_mis), 0);
    complete(4);
    chk("simul_tail_head", int'(s_head), 7);
    chk("simul_tail_cnt", int'(s_cnt), 1);
    message_source = 8'd7;
    #1;
    chk("simul_tail_rd", int'(s_rd), 1);
    // T6 allocation blocked by processing_response
    processing_response = 1'b1;
    alloc(9, 1'b0);
    alloc(9, 1'b0);
    processing_response = 1'b0;
    chk("block_cnt", int'(s_cnt), 1);
    alloc(9, 1'b0);
    alloc(10, 1'b0);
    alloc(11, 1'b0);
    chk("refill_cnt", int'(s_cnt), 4);
    chk("refill_tf", int'(s_tf), 1);
    // full table: retire proceeds but the same-cycle allocation is dropped
    response_awaited = 1'b1;
    transaction_target = 8'd12;
    complete(7);
    response_awaited = 1'b0;
    chk("full_simul_cnt", int'(s_cnt), 3);
    chk("full_simul_tf", int'(s_tf), 0);
    chk("full_simul_head", int'(s_head), 9);
    complete(12);
    chk("full_simul_drop_mis", int'(r_mis), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
